siso_d_ff: RTL and testbench
============================

SISO_D_FF -- requirements
Module: siso_d_ff

Interface
REQ-001 Parameter: WIDTH, default 4, number of shift stages; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: d_sin  input  1  serial data in.
REQ-005 Port: q_sout  output  1  serial data out, equals q[WIDTH-1].
REQ-006 Port: q  output  WIDTH  parallel view of all stages; q[0] is the newest bit, q[WIDTH-1] the oldest.
REQ-007 Port: shift_en  input  1  present only when SISO_SHIFT_ENABLE_EN is defined; see Configuration.
REQ-008 The block SHALL use exactly one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-009 On each rising clk edge with rst=0, the block SHALL update q <= {q[WIDTH-2:0], d_sin}.
REQ-010 q_sout SHALL be driven directly from stage WIDTH-1 register output, no combinational path from d_sin.
REQ-011 Latency: a bit sampled on d_sin at edge k SHALL appear on q[0] after edge k and on q_sout after edge k+WIDTH-1 (WIDTH-cycle serial delay).
REQ-012 The bit ordering SHALL be preserved: q_sout reproduces the d_sin sequence delayed by WIDTH cycles, with no inversion.
REQ-013 All outputs SHALL be registered; q and q_sout SHALL change only on rising clk edges.
REQ-014 X/unknown on d_sin SHALL propagate stage by stage only; no other stage is affected.

Reset
REQ-015 When rst=1 at a rising edge, all stages SHALL load 0, so q=0 and q_sout=0 after that edge.
REQ-016 rst SHALL take priority over shifting and over shift_en.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight bits; the first bit after release is sampled at the first edge with rst=0.
REQ-018 Before the first reset edge, register contents are undefined; no power-on value is guaranteed.

Configuration
REQ-019 Macro SISO_SHIFT_ENABLE_EN: when defined, port shift_en SHALL exist; with rst=0, shift_en=1 shifts per REQ-009, and shift_en=0 holds q unchanged.
REQ-020 Without SISO_SHIFT_ENABLE_EN, port shift_en SHALL be absent and the register SHALL shift on every non-reset edge.

Structure
REQ-021 A shared package siso_pkg SHALL hold the default width constant SISO_DEF_WIDTH=4.
REQ-022 The per-stage storage SHALL be a sub-module d_ff.
REQ-023 d_ff SHALL have ports clk, rst, en, d and q, with synchronous active-high reset to 0.
REQ-024 siso_d_ff SHALL instantiate WIDTH d_ff stages in a generate loop, chaining each stage's q to the next stage's d.

Verification
REQ-025 Reset then hold: rst=1 for 2 edges, d_sin=1 -> q=4'b0000, q_sout=0.
REQ-026 Single-one propagation: release rst, d_sin=1 for one edge then 0 -> q goes 0001, 0010, 0100, 1000, 0000; q_sout=1 only after the 4th edge.
REQ-027 Sequence 1,0,1,1,1,0,0,1,0,0,1,1 applied one bit per edge -> q_sout reproduces the same sequence delayed 4 edges; at the end q=4'b0011.
REQ-028 Mid-stream reset: after shifting 1111, assert rst for one edge -> q=0000 at that edge; shifting resumes on the next edge.
REQ-029 With SISO_SHIFT_ENABLE_EN: load 1010, hold shift_en=0 for 3 edges with d_sin=1 -> q stays 1010; re-assert shift_en -> next q=0101.
REQ-030 Width sweep: WIDTH=2 and WIDTH=8 with a single one -> q_sout=1 exactly after edge 2 and edge 8 respectively.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared constants for the serial-in/serial-out shift register.
package siso_pkg;

  localparam int SISO_DEF_WIDTH = 4;

endpackage

// File: rtl/siso_d_ff_d_ff.sv
// Single storage stage: D flip-flop with synchronous active-high reset and load enable.
module d_ff (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Reset wins over the enable so a held stage still clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/siso_d_ff.sv
// WIDTH-stage serial-in/serial-out shift register built from d_ff stages.
// Optional macro SISO_SHIFT_ENABLE_EN adds a shift_en port that freezes the chain when low.
module siso_d_ff
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_sin,
`ifdef SISO_SHIFT_ENABLE_EN
  input  logic             shift_en,
`endif
  output logic             q_sout,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] stage_q;
  logic             stage_en;

`ifdef SISO_SHIFT_ENABLE_EN
  assign stage_en = shift_en;
`else
  assign stage_en = 1'b1;
`endif

  // Stage 0 takes the serial input; every later stage takes its predecessor.
  always_comb begin
    stage_d = {stage_q[WIDTH-2:0], d_sin};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    d_ff u_stage (
      .clk (clk),
      .rst (rst),
      .en  (stage_en),
      .d   (stage_d[i]),
      .q   (stage_q[i])
    );
  end

  assign q      = stage_q;
  assign q_sout = stage_q[WIDTH-1];

endmodule

// File: tb/tb_siso_d_ff.sv
// Directed self-checking bench for siso_d_ff at WIDTH 4, 2 and 8.
// Define SISO_SHIFT_ENABLE_EN to also exercise the shift-enable hold behaviour.
module tb_siso_d_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_sin;
`ifdef SISO_SHIFT_ENABLE_EN
  logic       shift_en;
`endif
  logic       q_sout4, q_sout2, q_sout8;
  logic [3:0] q4;
  logic [1:0] q2;
  logic [7:0] q8;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  siso_d_ff #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .d_sin(d_sin),
`ifdef SISO_SHIFT_ENABLE_EN
    .shift_en(shift_en),
`endif
    .q_sout(q_sout4), .q(q4)
  );

  siso_d_ff #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .d_sin(d_sin),
`ifdef SISO_SHIFT_ENABLE_EN
    .shift_en(shift_en),
`endif
    .q_sout(q_sout2), .q(q2)
  );

  siso_d_ff #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .d_sin(d_sin),
`ifdef SISO_SHIFT_ENABLE_EN
    .shift_en(shift_en),
`endif
    .q_sout(q_sout8), .q(q8)
  );

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic applyStimulus(input logic r, input logic din);
    rst   = r;
    d_sin = din;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  logic seqBits [12] = '{1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1};

  initial begin
    rst   = 1'b1;
    d_sin = 1'b1;
`ifdef SISO_SHIFT_ENABLE_EN
    shift_en = 1'b1;
`endif
    @(negedge clk);

    // Reset held for two edges with d_sin high.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_q4", 32'(q4), 32'h0);
    checkOutput("reset_sout4", 32'(q_sout4), 32'h0);
    checkOutput("reset_q2", 32'(q2), 32'h0);
    checkOutput("reset_q8", 32'(q8), 32'h0);

    // Single one walks through all three widths.
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0, (e == 1) ? 1'b1 : 1'b0);
      checkOutput($sformatf("walk_q4_e%0d", e), 32'(q4),
                  (e <= 4) ? (32'h1 << (e - 1)) : 32'h0);
      checkOutput($sformatf("walk_sout4_e%0d", e), 32'(q_sout4), 32'(e == 4));
      checkOutput($sformatf("walk_sout2_e%0d", e), 32'(q_sout2), 32'(e == 2));
      checkOutput($sformatf("walk_sout8_e%0d", e), 32'(q_sout8), 32'(e == 8));
      checkOutput($sformatf("walk_q8_e%0d", e), 32'(q8), 32'h1 << (e - 1));
    end

    // Sequence reproduced on q_sout four edges later.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, seqBits[k]);
      checkOutput($sformatf("seq_sout4_e%0d", k + 1), 32'(q_sout4),
                  (k >= 3) ? 32'(seqBits[k - 3]) : 32'h0);
    end
    checkOutput("seq_final_q4", 32'(q4), 32'h3);

    // Mid-stream reset discards 1111, then shifting resumes.
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("mid_full_q4", 32'(q4), 32'hF);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rst_q4", 32'(q4), 32'h0);
    checkOutput("mid_rst_sout4", 32'(q_sout4), 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mid_resume_q4", 32'(q4), 32'h1);

`ifdef SISO_SHIFT_ENABLE_EN
    // Load 1010, freeze for three edges, then one more shift.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("en_load_q4", 32'(q4), 32'hA);
    shift_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("en_hold_q4_e%0d", k + 1), 32'(q4), 32'hA);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("en_rst_priority_q4", 32'(q4), 32'h0);
    shift_en = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("en_resume_q4", 32'(q4), 32'h5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
